// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic inter-stage pipeline register with a 2-entry skid buffer.
// in_ready and out_valid are flops, so there is no combinational path from out_ready
// to in_ready. Bubbles always present ctrl = 0 so they behave as NOPs downstream.
module pipe_stage_skid #(
  parameter int CTRL_W   = 8,
  parameter int DATA_W   = 160,
  parameter int CLR_DATA = 0,
  parameter int STALL_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [CTRL_W-1:0]   main_ctrl;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic [DATA_W-1:0]   main_data;
  logic [DATA_W-1:0]   skid_data;

  logic accept;
  logic drain;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  // Load enables for the two storage slots, derived from the current occupancy
  always_comb begin
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: ld_main_in = accept;
      ONE: begin
        ld_main_in = accept & drain;
        ld_skid    = accept & ~drain;
      end
      FULL:    ld_main_skid = drain;
      default: ;
    endcase
  end

  // Occupancy FSM with registered handshake outputs and ctrl storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_ctrl   <= '0;
      skid_ctrl   <= '0;
    end else if (flush) begin
      // Bubble: drop both entries and any same-cycle accept
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_ctrl   <= '0;
      skid_ctrl   <= '0;
    end else begin
      if (ld_main_in)   main_ctrl <= in_ctrl;
      if (ld_main_skid) main_ctrl <= skid_ctrl;
      if (ld_skid)      skid_ctrl <= in_ctrl;
      case (state)
        EMPTY: begin
          // in_ready also rises here on the first edge after reset release
          in_ready_q <= 1'b1;
          if (accept) begin
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (!accept && drain) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Payload storage; not gated by valid, optionally cleared on flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      if (CLR_DATA != 0) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      if (ld_main_in)        main_data <= in_data;
      else if (ld_main_skid) main_data <= skid_data;
      if (ld_skid)           skid_data <= in_data;
    end
  end

  // Saturating back-pressure counter; survives flush, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid_q && !out_ready && (stall_cnt != {STALL_W{1'b1}}))
      stall_cnt <= stall_cnt + STALL_W'(1);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl & {CTRL_W{out_valid_q}};
  assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two instances share stimulus (CLR_DATA=0/STALL_W=16 and
// CLR_DATA=1/STALL_W=3) and are compared each cycle against a queue-based FIFO model.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [7:0]   in_ctrl;
  logic [159:0] in_data;
  logic         out_ready;

  logic         in_ready0, out_valid0, in_ready1, out_valid1;
  logic [7:0]   out_ctrl0, out_ctrl1;
  logic [159:0] out_data0, out_data1;
  logic [15:0]  stall0;
  logic [2:0]   stall1;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(160), .CLR_DATA(0), .STALL_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .stall_cnt(stall0));

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(160), .CLR_DATA(1), .STALL_W(3)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .stall_cnt(stall1));

  typedef struct packed {
    logic [7:0]   c;
    logic [159:0] d;
  } ent_t;

  ent_t         q[$];
  int           st0, st1;
  int           n_cmp = 0;
  int           n_bad = 0;
  int unsigned  seq = 1;
  bit           post_rst;
  bit           chk_clr;
  bit           have_hold;
  logic [159:0] hold_data;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input bit r, input bit f);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_ctrl   = 8'($urandom);
    in_data   = {seq, $urandom, $urandom, $urandom, $urandom};
    seq++;
  endtask

  // Compare both instances against the model's current contents
  task automatic check_outs();
    logic [7:0] exp_c;
    exp_c = (q.size() > 0) ? q[0].c : 8'h00;
    chk("out_valid0", 160'(out_valid0), 160'(q.size() > 0));
    chk("out_valid1", 160'(out_valid1), 160'(q.size() > 0));
    chk("out_ctrl0", 160'(out_ctrl0), 160'(exp_c));
    chk("out_ctrl1", 160'(out_ctrl1), 160'(exp_c));
    if (q.size() > 0) begin
      chk("out_data0", out_data0, q[0].d);
      chk("out_data1", out_data1, q[0].d);
    end
    if (!post_rst) begin
      chk("in_ready0", 160'(in_ready0), 160'(q.size() < 2));
      chk("in_ready1", 160'(in_ready1), 160'(q.size() < 2));
    end
    chk("stall0", 160'(stall0), 160'(st0));
    chk("stall1", 160'(stall1), 160'(st1));
    if (chk_clr)   chk("flush_clr_data1", out_data1, 160'd0);
    if (have_hold) chk("flush_hold_data0", out_data0, hold_data);
  endtask

  // One clock: check, then advance the model with the inputs seen at the edge
  task automatic tick();
    bit acc, drn;
    ent_t e;
    check_outs();
    @(posedge clk);
    if (q.size() > 0 && !out_ready) begin
      if (st0 < 65535) st0++;
      if (st1 < 7)     st1++;
    end
    chk_clr   = 1'b0;
    have_hold = 1'b0;
    if (flush) begin
      if (q.size() > 0) begin
        hold_data = q[0].d;
        have_hold = 1'b1;
      end
      chk_clr = 1'b1;
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (drn) void'(q.pop_front());
      if (acc) begin
        e.c = in_ctrl;
        e.d = in_data;
        q.push_back(e);
      end
    end
    post_rst = 1'b0;
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid0"}, 160'(out_valid0), 160'd0);
    chk({tag, "_valid1"}, 160'(out_valid1), 160'd0);
    chk({tag, "_ctrl0"}, 160'(out_ctrl0), 160'd0);
    chk({tag, "_ctrl1"}, 160'(out_ctrl1), 160'd0);
    chk({tag, "_data0"}, out_data0, 160'd0);
    chk({tag, "_data1"}, out_data1, 160'd0);
    chk({tag, "_rdy0"}, 160'(in_ready0), 160'd0);
    chk({tag, "_stall0"}, 160'(stall0), 160'd0);
    chk({tag, "_stall1"}, 160'(stall1), 160'd0);
  endtask

  // Reset pulse placed between clock edges, followed by one idle cycle
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1 check_reset_state("rst_mid");
    q.delete();
    st0 = 0;
    st1 = 0;
    chk_clr   = 1'b0;
    have_hold = 1'b0;
    #1 rst = 1'b0;
    post_rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    st0 = 0;
    st1 = 0;
    post_rst  = 1'b1;
    chk_clr   = 1'b0;
    have_hold = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 check_reset_state("rst_init");
    #2 rst = 1'b0;
    tick();

    // T1 streaming at full throughput
    repeat (8) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("t1_stall0", 160'(stall0), 160'd0);

    // T2 back-pressure and T5 saturation from a clean counter
    mid_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    repeat (5) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("t2_full_rdy0", 160'(in_ready0), 160'd0);
    chk("t2_stall0", 160'(stall0), 160'd5);
    repeat (5) begin
      drive(1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("t5_stall1_sat", 160'(stall1), 160'd7);
    chk("t5_stall0", 160'(stall0), 160'd10);
    repeat (3) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end

    // T3 flush while FULL with a valid input carrying all-ones ctrl
    repeat (2) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1);
    in_ctrl = 8'hFF;
    tick();
    chk("t3_valid0", 160'(out_valid0), 160'd0);
    chk("t3_ctrl0", 160'(out_ctrl0), 160'd0);
    chk("t3_rdy0", 160'(in_ready0), 160'd1);
    repeat (3) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end

    // T4 async reset mid-stream, then first input after release
    repeat (4) begin
      drive(1'b1, ($urandom_range(1) == 1), 1'b0);
      tick();
    end
    mid_reset();
    drive(1'b1, 1'b1, 1'b0);
    tick();
    chk("t4_first_valid0", 160'(out_valid0), 160'd1);

    // T6 random valid/ready/flush with occasional async reset
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(3) != 0), ($urandom_range(2) != 0), ($urandom_range(49) == 0));
      tick();
      if (i % 700 == 350) mid_reset();
    end
    check_outs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
